// File: rtl/training_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : training_sequencer
// Purpose  : Epoch-loop controller for the weight-path datapath; drives the
//            initial-guess, training, best-weight buffer and finish strobes.
// Revision : 1.0 - initial release
// ============================================================================
module training_sequencer #(
    parameter int BIT_WIDTH    = 32,
    parameter int EXTRA_BITS   = 2,
    parameter int NUM_UNKNOWNS = 2,
    parameter int MAX_EPOCHS   = 256,
    parameter int EPOCH_W      = 8,
    parameter logic [BIT_WIDTH+EXTRA_BITS-1:0] ERROR_THRESHOLD = 34'h0_0000_0100
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic                            start,
    input  logic                            abort,
    input  logic                            error_valid,
    input  logic [BIT_WIDTH+EXTRA_BITS-1:0] l2_error,
    output logic                            training_mode,
    output logic                            initial_read_flag,
    output logic                            training_wr,
    output logic                            training_rd,
    output logic                            write_best,
    output logic                            finish,
    output logic                            stall,
    output logic                            busy,
    output logic                            done,
    output logic [EPOCH_W-1:0]              epoch_count,
    output logic [BIT_WIDTH+EXTRA_BITS-1:0] best_error
);

    localparam int c_ERR_W  = BIT_WIDTH + EXTRA_BITS;
    localparam int c_BEAT_W = (NUM_UNKNOWNS > 1) ? $clog2(NUM_UNKNOWNS) : 1;

    localparam logic [c_BEAT_W-1:0] c_BEAT_LAST  = c_BEAT_W'(NUM_UNKNOWNS - 1);
    localparam logic [EPOCH_W-1:0]  c_EPOCH_LAST = EPOCH_W'(MAX_EPOCHS - 1);
    localparam logic [c_ERR_W-1:0]  c_ERR_ONES   = '1;

    localparam logic [2:0] c_S_IDLE      = 3'd0;
    localparam logic [2:0] c_S_LOAD_INIT = 3'd1;
    localparam logic [2:0] c_S_WAIT_ERR  = 3'd2;
    localparam logic [2:0] c_S_SAVE_BEST = 3'd3;
    localparam logic [2:0] c_S_UPDATE    = 3'd4;
    localparam logic [2:0] c_S_READBACK  = 3'd5;
    localparam logic [2:0] c_S_DONE      = 3'd6;

    logic [2:0]          r_state;
    logic [c_BEAT_W-1:0] r_beat;
    logic [EPOCH_W-1:0]  r_epoch;
    logic [c_ERR_W-1:0]  r_best;
    logic [c_ERR_W-1:0]  r_cur_err;

    logic r_init;
    logic r_train;
    logic r_wb;
    logic r_fin;
    logic r_stall;
    logic r_busy;
    logic r_done;

    logic [2:0]          w_state_nxt;
    logic [c_BEAT_W-1:0] w_beat_nxt;
    logic [EPOCH_W-1:0]  w_epoch_nxt;
    logic [c_ERR_W-1:0]  w_best_nxt;
    logic [c_ERR_W-1:0]  w_cur_err_nxt;
    logic [c_BEAT_W-1:0] w_beat_inc;
    logic                w_beat_last;
    logic                w_epoch_at_limit;
    logic                w_err_improved;
    logic                w_err_term;
    logic                w_cur_term;

    logic w_init_nxt;
    logic w_train_nxt;
    logic w_wb_nxt;
    logic w_fin_nxt;
    logic w_stall_nxt;
    logic w_busy_nxt;
    logic w_done_nxt;

    assign w_beat_inc       = r_beat + 1'b1;
    assign w_beat_last      = (r_beat == c_BEAT_LAST);
    assign w_epoch_at_limit = (r_epoch == c_EPOCH_LAST);
    // Equal error is deliberately not an improvement.
    assign w_err_improved   = (l2_error < r_best);
    assign w_err_term       = (l2_error < ERROR_THRESHOLD) || w_epoch_at_limit;
    assign w_cur_term       = (r_cur_err < ERROR_THRESHOLD) || w_epoch_at_limit;

    always_comb begin
        w_state_nxt   = r_state;
        w_beat_nxt    = r_beat;
        w_epoch_nxt   = r_epoch;
        w_best_nxt    = r_best;
        w_cur_err_nxt = r_cur_err;

        case (r_state)
            c_S_IDLE, c_S_DONE: begin
                if (start) begin
                    w_state_nxt = c_S_LOAD_INIT;
                    w_beat_nxt  = '0;
                    w_epoch_nxt = '0;
                    w_best_nxt  = c_ERR_ONES;
                end
            end
            c_S_LOAD_INIT: begin
                if (abort) begin
                    w_state_nxt = c_S_READBACK;
                    w_beat_nxt  = '0;
                end else if (w_beat_last) begin
                    w_state_nxt = c_S_WAIT_ERR;
                    w_beat_nxt  = '0;
                end else begin
                    w_beat_nxt = w_beat_inc;
                end
            end
            c_S_WAIT_ERR: begin
                w_beat_nxt = '0;
                if (abort) begin
                    w_state_nxt = c_S_READBACK;
                end else if (error_valid) begin
                    w_cur_err_nxt = l2_error;
                    if (w_err_improved) begin
                        w_state_nxt = c_S_SAVE_BEST;
                        w_best_nxt  = l2_error;
                    end else if (w_err_term) begin
                        w_state_nxt = c_S_READBACK;
                    end else begin
                        w_state_nxt = c_S_UPDATE;
                    end
                end
            end
            c_S_SAVE_BEST: begin
                if (abort) begin
                    w_state_nxt = c_S_READBACK;
                    w_beat_nxt  = '0;
                end else if (w_beat_last) begin
                    w_state_nxt = w_cur_term ? c_S_READBACK : c_S_UPDATE;
                    w_beat_nxt  = '0;
                end else begin
                    w_beat_nxt = w_beat_inc;
                end
            end
            c_S_UPDATE: begin
                if (abort) begin
                    w_state_nxt = c_S_READBACK;
                    w_beat_nxt  = '0;
                end else if (w_beat_last) begin
                    w_state_nxt = c_S_WAIT_ERR;
                    w_beat_nxt  = '0;
                    w_epoch_nxt = w_epoch_at_limit ? r_epoch : r_epoch + 1'b1;
                end else begin
                    w_beat_nxt = w_beat_inc;
                end
            end
            c_S_READBACK: begin
                if (w_beat_last) begin
                    w_state_nxt = c_S_DONE;
                    w_beat_nxt  = '0;
                end else begin
                    w_beat_nxt = w_beat_inc;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
                w_beat_nxt  = '0;
            end
        endcase
    end

    // Strobes are decoded from the next state so they register alongside it.
    always_comb begin
        w_init_nxt  = (w_state_nxt == c_S_LOAD_INIT);
        w_train_nxt = (w_state_nxt == c_S_UPDATE);
        w_wb_nxt    = (w_state_nxt == c_S_SAVE_BEST);
        w_fin_nxt   = (w_state_nxt == c_S_READBACK);
        w_stall_nxt = (w_state_nxt == c_S_WAIT_ERR);
        w_done_nxt  = (w_state_nxt == c_S_DONE);
        w_busy_nxt  = !((w_state_nxt == c_S_IDLE) || (w_state_nxt == c_S_DONE));
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= c_S_IDLE;
            r_beat    <= '0;
            r_epoch   <= '0;
            r_best    <= c_ERR_ONES;
            r_cur_err <= '0;
            r_init    <= 1'b0;
            r_train   <= 1'b0;
            r_wb      <= 1'b0;
            r_fin     <= 1'b0;
            r_stall   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_beat    <= w_beat_nxt;
            r_epoch   <= w_epoch_nxt;
            r_best    <= w_best_nxt;
            r_cur_err <= w_cur_err_nxt;
            r_init    <= w_init_nxt;
            r_train   <= w_train_nxt;
            r_wb      <= w_wb_nxt;
            r_fin     <= w_fin_nxt;
            r_stall   <= w_stall_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign training_mode     = r_busy;
    assign busy              = r_busy;
    assign initial_read_flag = r_init;
    assign training_wr       = r_train;
    assign training_rd       = r_train;
    assign write_best        = r_wb;
    assign finish            = r_fin;
    assign stall             = r_stall;
    assign done              = r_done;
    assign epoch_count       = r_epoch;
    assign best_error        = r_best;

endmodule
`default_nettype wire

// File: tb/tb_training_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_training_sequencer
// Purpose  : Directed bench with a queue-based schedule model of the epoch loop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_training_sequencer;

    localparam int BW = 32;
    localparam int EB = 2;
    localparam int NU = 2;
    localparam int ME = 4;
    localparam int EW = 8;
    localparam int DW = BW + EB;

    localparam logic [DW-1:0] THR     = 34'h0_0000_0100;
    localparam logic [DW-1:0] ONES    = '1;
    localparam logic [EW-1:0] EP_LAST = EW'(ME - 1);

    // {init, wr, rd, write_best, finish, stall, done}
    localparam logic [6:0] S_IDLE  = 7'b0000000;
    localparam logic [6:0] S_INIT  = 7'b1000000;
    localparam logic [6:0] S_UPD   = 7'b0110000;
    localparam logic [6:0] S_WB    = 7'b0001000;
    localparam logic [6:0] S_FIN   = 7'b0000100;
    localparam logic [6:0] S_STALL = 7'b0000010;
    localparam logic [6:0] S_DONE  = 7'b0000001;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          error_valid = 1'b0;
    logic [DW-1:0] l2_error = '0;
    logic          training_mode, initial_read_flag, training_wr, training_rd;
    logic          write_best, finish, stall, busy, done;
    logic [EW-1:0] epoch_count;
    logic [DW-1:0] best_error;

    training_sequencer #(
        .BIT_WIDTH(BW), .EXTRA_BITS(EB), .NUM_UNKNOWNS(NU),
        .MAX_EPOCHS(ME), .EPOCH_W(EW), .ERROR_THRESHOLD(THR)
    ) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .abort(abort),
        .error_valid(error_valid), .l2_error(l2_error),
        .training_mode(training_mode), .initial_read_flag(initial_read_flag),
        .training_wr(training_wr), .training_rd(training_rd),
        .write_best(write_best), .finish(finish), .stall(stall),
        .busy(busy), .done(done), .epoch_count(epoch_count),
        .best_error(best_error)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each event schedules the exact sequence of output cycles it causes.
    typedef struct packed {
        logic [6:0]    s;
        logic [EW-1:0] ep;
        logic [DW-1:0] be;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    exp_t rest;
    logic          m_imp, m_term;
    logic [DW-1:0] m_nb;

    function automatic exp_t mk(input logic [6:0] s, input logic [EW-1:0] ep, input logic [DW-1:0] be);
        exp_t e;
        e.s = s; e.ep = ep; e.be = be;
        return e;
    endfunction

    task automatic push_burst(input logic [6:0] s, input logic [EW-1:0] ep, input logic [DW-1:0] be);
        for (int i = 0; i < NU; i++) q.push_back(mk(s, ep, be));
    endtask

    initial begin
        cur  = mk(S_IDLE, '0, ONES);
        rest = mk(S_IDLE, '0, ONES);
        forever begin
            @(posedge CLK);
            if (RESET) begin
                q.delete();
                cur  = mk(S_IDLE, '0, ONES);
                rest = cur;
            end else if (abort && (cur.s inside {S_INIT, S_STALL, S_WB, S_UPD})) begin
                q.delete();
                push_burst(S_FIN, cur.ep, cur.be);
                rest = mk(S_DONE, cur.ep, cur.be);
                cur  = q.pop_front();
            end else if (cur.s == S_STALL && error_valid) begin
                m_imp  = l2_error < cur.be;
                m_nb   = m_imp ? l2_error : cur.be;
                m_term = (l2_error < THR) || (cur.ep == EP_LAST);
                if (m_imp) push_burst(S_WB, cur.ep, m_nb);
                if (m_term) begin
                    push_burst(S_FIN, cur.ep, m_nb);
                    rest = mk(S_DONE, cur.ep, m_nb);
                end else begin
                    push_burst(S_UPD, cur.ep, m_nb);
                    rest = mk(S_STALL, (cur.ep == EP_LAST) ? cur.ep : cur.ep + 1'b1, m_nb);
                end
                cur = q.pop_front();
            end else if ((cur.s == S_IDLE || cur.s == S_DONE) && start) begin
                push_burst(S_INIT, '0, ONES);
                rest = mk(S_STALL, '0, ONES);
                cur  = q.pop_front();
            end else if (q.size() > 0) begin
                cur = q.pop_front();
            end else begin
                cur = rest;
            end
        end
    end

    initial forever begin
        @(negedge CLK);
        if (chk_en) begin
            check("strobes", 64'({initial_read_flag, training_wr, training_rd,
                                  write_best, finish, stall, done}), 64'(cur.s));
            check("busy", 64'({busy, training_mode}),
                  (cur.s == S_IDLE || cur.s == S_DONE) ? 64'd0 : 64'd3);
            check("epoch_count", 64'(epoch_count), 64'(cur.ep));
            check("best_error", 64'(best_error), 64'(cur.be));
        end
    end

    int n_wb = 0, n_wr = 0, n_fin = 0;
    initial forever begin
        @(negedge CLK);
        if (write_best)  n_wb++;
        if (training_wr) n_wr++;
        if (finish)      n_fin++;
    end

    int s_wb, s_wr, s_fin;
    task automatic snap();
        s_wb = n_wb; s_wr = n_wr; s_fin = n_fin;
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic wait_stall();
        int n;
        n = 0;
        while (stall !== 1'b1 && n < 50) begin tick(); n++; end
        if (stall !== 1'b1) check("wait_stall_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 50) begin tick(); n++; end
        if (done !== 1'b1) check("wait_done_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_err(input logic [DW-1:0] v);
        wait_stall();
        error_valid = 1'b1; l2_error = v;
        tick();
        error_valid = 1'b0; l2_error = '0;
    endtask

    initial begin
        RESET = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        RESET = 1'b0;
        check("rst_strobes", 64'({initial_read_flag, training_wr, write_best, finish, stall, done, busy}), 64'd0);
        check("rst_best", 64'(best_error), 64'h3_FFFF_FFFF);
        check("rst_epoch", 64'(epoch_count), 64'd0);

        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_idle_ignored", 64'(busy), 64'd0);

        pulse_start();
        check("init_c1", 64'(initial_read_flag), 64'd1);
        tick();
        check("init_c2", 64'(initial_read_flag), 64'd1);
        tick();
        check("init_c3_off", 64'(initial_read_flag), 64'd0);
        check("stall_after_init", 64'(stall), 64'd1);
        pulse_start();
        check("start_ignored_wait", 64'(stall), 64'd1);

        // Improving run
        snap();
        send_err(34'h1000);
        send_err(34'h0800);
        send_err(34'h0400);
        wait_stall();
        check("impr_best", 64'(best_error), 64'h400);
        check("impr_epoch", 64'(epoch_count), 64'd3);
        check("impr_wb_cycles", 64'(n_wb - s_wb), 64'd6);
        check("impr_wr_cycles", 64'(n_wr - s_wr), 64'd6);

        // Abort beats a coincident error
        abort = 1'b1; error_valid = 1'b1; l2_error = 34'h10;
        tick();
        abort = 1'b0; error_valid = 1'b0; l2_error = '0;
        check("abort_finish", 64'(finish), 64'd1);
        check("abort_best_kept", 64'(best_error), 64'h400);
        wait_done();
        check("abort_done_epoch", 64'(epoch_count), 64'd3);

        // Non-improving and equal errors, then reset mid-UPDATE
        pulse_start();
        snap();
        send_err(34'h0800);
        send_err(34'h0800);
        wait_stall();
        check("eq_epoch", 64'(epoch_count), 64'd2);
        check("eq_best", 64'(best_error), 64'h800);
        send_err(34'h0900);
        check("nonimpr_update", 64'(training_wr), 64'd1);
        check("eq_wb_cycles", 64'(n_wb - s_wb), 64'd2);
        RESET = 1'b1;
        tick();
        check("midrst_wr", 64'(training_wr), 64'd0);
        check("midrst_epoch", 64'(epoch_count), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_best", 64'(best_error), 64'h3_FFFF_FFFF);
        RESET = 1'b0;
        tick();

        // Convergence, with a stray error_valid during LOAD_INIT
        pulse_start();
        error_valid = 1'b1; l2_error = 34'h1;
        tick();
        error_valid = 1'b0; l2_error = '0;
        snap();
        send_err(34'h1000);
        send_err(34'h00FF);
        check("conv_wb1", 64'(write_best), 64'd1);
        tick();
        check("conv_wb2", 64'(write_best), 64'd1);
        tick();
        check("conv_fin1", 64'(finish), 64'd1);
        tick();
        check("conv_fin2", 64'(finish), 64'd1);
        tick();
        check("conv_done", 64'(done), 64'd1);
        check("conv_epoch", 64'(epoch_count), 64'd1);
        check("conv_best", 64'(best_error), 64'hFF);
        check("conv_wr_cycles", 64'(n_wr - s_wr), 64'd2);

        // Epoch limit
        pulse_start();
        snap();
        for (int i = 0; i < 4; i++) send_err(34'h0500);
        wait_done();
        check("lim_epoch", 64'(epoch_count), 64'd3);
        check("lim_wb_cycles", 64'(n_wb - s_wb), 64'd2);
        check("lim_wr_cycles", 64'(n_wr - s_wr), 64'd6);
        check("lim_fin_cycles", 64'(n_fin - s_fin), 64'd2);
        check("lim_best", 64'(best_error), 64'h500);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
